// File: rtl/battleship_game_ctrl_if.sv
// battleship_game_ctrl_if: button/ship-map inputs and board/cursor/status outputs of the game controller.
interface battleship_game_ctrl_if;
   logic                  start;
   logic                  btn_up;
   logic                  btn_down;
   logic                  btn_left;
   logic                  btn_right;
   logic                  btn_fire;
   logic [24:0]           ships_jugador;
   logic [24:0]           ships_pc;
   logic [2:0]            i_actual;
   logic [2:0]            j_actual;
   logic [4:0][4:0][1:0]  tablero_jugador;
   logic [4:0][4:0][1:0]  tablero_pc;
   logic                  turn;
   logic                  game_over;
   logic                  winner;
   modport master (
      output start, btn_up, btn_down, btn_left, btn_right, btn_fire, ships_jugador, ships_pc,
      input  i_actual, j_actual, tablero_jugador, tablero_pc, turn, game_over, winner
   );
   modport slave (
      input  start, btn_up, btn_down, btn_left, btn_right, btn_fire, ships_jugador, ships_pc,
      output i_actual, j_actual, tablero_jugador, tablero_pc, turn, game_over, winner
   );
endinterface

// File: rtl/battleship_game_ctrl.sv
// battleship_game_ctrl: turn-based 5x5 battleship controller with cursor, both boards, LFSR PC shots and winner detection.
module battleship_game_ctrl #(
   parameter int         PC_DELAY  = 25000000,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input logic                   clk,
   input logic                   rst,
   battleship_game_ctrl_if.slave io
);
   localparam int CW = (PC_DELAY > 1) ? $clog2(PC_DELAY) : 1;
   typedef enum logic [2:0] {
      IDLE, PLAYER_TURN, PLAYER_RESOLVE, PC_WAIT, PC_PICK, PC_RESOLVE, GAME_OVER
   } state_t;
   state_t           r_state;
   logic [7:0]       r_lfsr;
   logic [CW-1:0]    r_cnt;
   logic [2:0]       r_i, r_j;
   logic [24:0][1:0] r_bj, r_bp;
   logic [4:0]       r_ships_j, r_ships_p, r_hits_j, r_hits_p;
   logic             r_hit, r_turn, r_game_over, r_winner;
   logic [4:0]       w_cur, w_idx, w_cnt_j, w_cnt_p, w_nh_p, w_nh_j;
   logic [1:0]       w_pcell, w_jcell;
   logic             w_fb;
   function automatic logic [24:0][1:0] load(input logic [24:0] s);
      logic [24:0][1:0] b;
      for (int k = 0; k < 25; k++) b[k] = {1'b0, s[k]};
      return b;
   endfunction
   always_comb begin
      w_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
      w_cur   = 5'(r_i) * 5'd5 + 5'(r_j);
      w_idx   = r_lfsr[4:0];
      w_pcell = r_bp[w_cur];
      w_jcell = (w_idx < 5'd25) ? r_bj[w_idx] : 2'b11;
      w_cnt_j = 5'($countones(io.ships_jugador));
      w_cnt_p = 5'($countones(io.ships_pc));
      w_nh_p  = r_hits_p + {4'd0, r_hit};
      w_nh_j  = r_hits_j + {4'd0, r_hit};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_lfsr      <= LFSR_SEED;
         r_cnt       <= '0;
         r_i         <= '0;
         r_j         <= '0;
         r_bj        <= '0;
         r_bp        <= '0;
         r_ships_j   <= '0;
         r_ships_p   <= '0;
         r_hits_j    <= '0;
         r_hits_p    <= '0;
         r_hit       <= 1'b0;
         r_turn      <= 1'b0;
         r_game_over <= 1'b0;
         r_winner    <= 1'b0;
      end else begin
         r_lfsr <= {r_lfsr[6:0], w_fb};
         case (r_state)
            IDLE, GAME_OVER: if (io.start) begin
               r_bj      <= load(io.ships_jugador);
               r_bp      <= load(io.ships_pc);
               r_ships_j <= w_cnt_j;
               r_ships_p <= w_cnt_p;
               r_hits_j  <= '0;
               r_hits_p  <= '0;
               r_i       <= '0;
               r_j       <= '0;
               r_turn    <= 1'b0;
               // an empty fleet ends the game at once; PC fleet checked first
               r_game_over <= (w_cnt_p == 5'd0) || (w_cnt_j == 5'd0);
               r_winner    <= (w_cnt_p != 5'd0);
               r_state     <= ((w_cnt_p == 5'd0) || (w_cnt_j == 5'd0)) ? GAME_OVER : PLAYER_TURN;
            end
            PLAYER_TURN: begin
               if (io.btn_fire) begin
                  if (!w_pcell[1]) begin
                     r_bp[w_cur] <= {1'b1, w_pcell[0]};
                     r_hit       <= w_pcell[0];
                     r_state     <= PLAYER_RESOLVE;
                  end
               end else if (io.btn_up)    r_i <= (r_i == 3'd0) ? 3'd4 : r_i - 3'd1;
               else if (io.btn_down)      r_i <= (r_i == 3'd4) ? 3'd0 : r_i + 3'd1;
               else if (io.btn_left)      r_j <= (r_j == 3'd0) ? 3'd4 : r_j - 3'd1;
               else if (io.btn_right)     r_j <= (r_j == 3'd4) ? 3'd0 : r_j + 3'd1;
            end
            PLAYER_RESOLVE: begin
               r_hits_p <= w_nh_p;
               if (w_nh_p == r_ships_p) begin
                  r_state     <= GAME_OVER;
                  r_game_over <= 1'b1;
                  r_winner    <= 1'b0;
               end else begin
                  r_state <= PC_WAIT;
                  r_turn  <= 1'b1;
                  r_cnt   <= CW'(PC_DELAY - 1);
               end
            end
            PC_WAIT: begin
               r_cnt   <= r_cnt - 1'b1;
               r_state <= (r_cnt == '0) ? PC_PICK : PC_WAIT;
            end
            PC_PICK: if (!w_jcell[1]) begin
               r_bj[w_idx] <= {1'b1, w_jcell[0]};
               r_hit       <= w_jcell[0];
               r_state     <= PC_RESOLVE;
            end
            PC_RESOLVE: begin
               r_hits_j <= w_nh_j;
               if (w_nh_j == r_ships_j) begin
                  r_state     <= GAME_OVER;
                  r_game_over <= 1'b1;
                  r_winner    <= 1'b1;
               end else begin
                  r_state <= PLAYER_TURN;
                  r_turn  <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign io.i_actual        = r_i;
   assign io.j_actual        = r_j;
   assign io.tablero_jugador = r_bj;
   assign io.tablero_pc      = r_bp;
   assign io.turn            = r_turn;
   assign io.game_over       = r_game_over;
   assign io.winner          = r_winner;
endmodule

// File: tb/tb_battleship_game_ctrl.sv
// tb_battleship_game_ctrl: directed scoreboard bench for the battleship game controller.
module tb_battleship_game_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   battleship_game_ctrl_if io();
   battleship_game_ctrl #(.PC_DELAY(4), .LFSR_SEED(8'hA5)) dut (.clk(clk), .rst(rst), .io(io));
   int checks = 0;
   int failures = 0;
   logic [63:0] sb[$];
   logic [49:0] before_j, before_p;
   int diffs;
   logic ok_cell;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic put(input logic [63:0] v);
      sb.push_back(v);
   endtask
   task automatic chk(input string tag, input logic [63:0] obs);
      logic [63:0] e;
      checks++;
      e = 64'hDEAD_BEEF_DEAD_BEEF;
      if (sb.size() > 0) e = sb.pop_front();
      assert (obs === e) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
   endtask
   task automatic press(input logic u, input logic d, input logic l, input logic r, input logic f);
      io.btn_up = u; io.btn_down = d; io.btn_left = l; io.btn_right = r; io.btn_fire = f;
      tick();
      io.btn_up = 0; io.btn_down = 0; io.btn_left = 0; io.btn_right = 0; io.btn_fire = 0;
   endtask
   task automatic go(input logic [24:0] pc, input logic [24:0] pj);
      io.ships_pc = pc; io.ships_jugador = pj; io.start = 1'b1;
      tick();
      io.start = 1'b0;
   endtask
   function automatic logic [49:0] mapb(input logic [24:0] s);
      logic [49:0] b;
      for (int k = 0; k < 25; k++) b[2*k +: 2] = {1'b0, s[k]};
      return b;
   endfunction
   initial begin
      io.start = 0; io.btn_up = 0; io.btn_down = 0; io.btn_left = 0; io.btn_right = 0; io.btn_fire = 0;
      io.ships_pc = '0; io.ships_jugador = '0;
      tick(); tick();
      rst = 1'b0;
      put(64'd0); chk("rst_pc_board", 64'(io.tablero_pc));
      put(64'd0); chk("rst_j_board", 64'(io.tablero_jugador));
      put(64'd0); chk("rst_cursor", 64'({io.i_actual, io.j_actual}));
      put(64'd0); chk("rst_turn_go", 64'({io.turn, io.game_over}));
      put(64'hA5); chk("rst_lfsr", 64'(dut.r_lfsr));
      // single-ship duel: one player hit wins
      go(25'd1, 25'd1 << 24);
      put(64'(mapb(25'd1))); chk("load_pc", 64'(io.tablero_pc));
      put(64'(mapb(25'd1 << 24))); chk("load_j", 64'(io.tablero_jugador));
      press(0, 0, 0, 0, 1);
      put(64'd3); chk("hit_cell", 64'(io.tablero_pc[0][0]));
      put(64'd0); chk("hit_not_over_yet", 64'(io.game_over));
      tick();
      put(64'b10); chk("player_wins", 64'({io.game_over, io.winner}));
      press(0, 0, 0, 0, 1);
      put(64'(mapb(25'd1) | 50'd2)); chk("go_fire_ignored", 64'(io.tablero_pc));
      // cursor wrap and priority
      go(25'd3, 25'd3 << 23);
      put(64'b00); chk("restart_go", 64'({io.game_over, io.turn}));
      press(1, 0, 0, 0, 0);
      put(64'({3'd4, 3'd0})); chk("up_wrap", 64'({io.i_actual, io.j_actual}));
      press(0, 0, 1, 0, 0);
      put(64'({3'd4, 3'd4})); chk("left_wrap", 64'({io.i_actual, io.j_actual}));
      press(0, 1, 0, 0, 0);
      put(64'({3'd0, 3'd4})); chk("down_wrap", 64'({io.i_actual, io.j_actual}));
      press(1, 0, 1, 0, 0);
      put(64'({3'd4, 3'd4})); chk("up_over_left", 64'({io.i_actual, io.j_actual}));
      press(1, 0, 0, 0, 0); press(1, 0, 0, 0, 0); press(0, 0, 1, 0, 0);
      put(64'({3'd2, 3'd3})); chk("nav_2_3", 64'({io.i_actual, io.j_actual}));
      before_j = io.tablero_jugador;
      press(0, 1, 0, 0, 1);
      put(64'(mapb(25'd3) | (50'd2 << 26))); chk("miss_cell", 64'(io.tablero_pc));
      put(64'({3'd2, 3'd3})); chk("fire_drops_move", 64'({io.i_actual, io.j_actual}));
      tick();
      put(64'd1); chk("pc_turn", 64'(io.turn));
      for (int k = 0; k < 300 && io.turn === 1'b1; k++) tick();
      put(64'd0); chk("pc_turn_done", 64'(io.turn));
      diffs = 0; ok_cell = 1'b0;
      for (int k = 0; k < 25; k++) if (before_j[2*k +: 2] !== io.tablero_jugador[k/5][k%5]) begin
         diffs++;
         ok_cell = (io.tablero_jugador[k/5][k%5] === (before_j[2*k +: 2] | 2'b10));
      end
      put(64'd1); chk("pc_one_cell", 64'(diffs));
      put(64'd1); chk("pc_cell_value", 64'(ok_cell));
      put(64'd0); chk("pc_not_over", 64'(io.game_over));
      before_p = io.tablero_pc;
      press(0, 0, 0, 0, 1);
      tick();
      put(64'(before_p)); chk("refire_ignored", 64'(io.tablero_pc));
      put(64'd0); chk("refire_turn", 64'(io.turn));
      // reset while the PC is waiting
      press(0, 0, 1, 0, 0);
      press(0, 0, 0, 0, 1);
      put(64'(mapb(25'd3) | (50'd2 << 26) | (50'd2 << 24))); chk("miss_2_2", 64'(io.tablero_pc));
      tick();
      put(64'd1); chk("wait_turn", 64'(io.turn));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      put(64'd0); chk("mid_rst_pc", 64'(io.tablero_pc));
      put(64'd0); chk("mid_rst_j", 64'(io.tablero_jugador));
      put(64'd0); chk("mid_rst_status", 64'({io.turn, io.game_over, io.i_actual, io.j_actual}));
      press(1, 0, 0, 0, 0);
      press(0, 0, 0, 0, 1);
      put(64'd0); chk("idle_buttons", 64'({io.tablero_pc, io.i_actual}));
      // empty fleets end the game immediately
      go(25'd0, 25'd1);
      put(64'b10); chk("empty_pc", 64'({io.game_over, io.winner}));
      press(0, 0, 0, 0, 1);
      put(64'd0); chk("empty_fire", 64'(io.tablero_pc));
      go(25'd3, 25'd0);
      put(64'b11); chk("empty_j", 64'({io.game_over, io.winner}));
      go(25'd3, 25'd1 << 24);
      put(64'(mapb(25'd3))); chk("reload_pc", 64'(io.tablero_pc));
      put(64'b00); chk("reload_status", 64'({io.game_over, io.turn}));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
